// File: rtl/mem_system_pkg.sv
// Shared definitions for the memory stage: access-size encoding, the fixed
// address map of the timer window and tohost, and the byte-enable helper.
package mem_system_pkg;

  typedef enum logic [1:0] {
    UNIT_BYTE = 2'd0,
    UNIT_HALF = 2'd1,
    UNIT_WORD = 2'd2
  } mem_unit_t;

  localparam logic [31:0] MTIMECMP_ADDR = 32'h0200_4000;
  localparam logic [31:0] MTIME_ADDR    = 32'h0200_BFF8;
  localparam logic [31:0] TOHOST_ADDR   = 32'h1000_0000;

  // Byte lanes touched by an access of size u at byte offset off.
  // Encoding 3 is reserved and touches nothing.
  function automatic logic [3:0] lane_be(input mem_unit_t u, input logic [1:0] off);
    case (u)
      UNIT_BYTE: return 4'b0001 << off;
      UNIT_HALF: return 4'b0011 << off;
      UNIT_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_system_ram.sv
// Word-organised on-chip RAM.
//   clk   : write clock
//   we    : write enable, be selects the byte lanes written
//   addr  : word index, shared by the write and the asynchronous read
//   wdata : lane-aligned write data
//   rdata : asynchronous read of the addressed word
// Contents are not reset.
module ram #(
  parameter int WORDS     = 16384,
  parameter int AW        = 14,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_system.sv
// Memory stage behind the core: address decode, fault flags, RAM, the
// mtime/mtimecmp register window (merged on the core's behalf) and tohost.
//   clk, reset            : clock, asynchronous active-low reset
//   mem_re/mem_we         : load / store request for this cycle
//   mem_addr, mem_wd      : byte address, right-aligned store data
//   mem_rd_unit/wd_unit   : access size (byte/half/word, 3 reserved)
//   mem_rd                : right-aligned, zero-extended load data
//   mtime, mtimecmp       : timer values held in the core
//   mtime_next/_we, mtimecmp_next : merged timer values for the core
//   access_fault, addr_misaligned : combinational request faults
//   tohost, halt          : host mailbox register and sticky halt
module mem_system
  import mem_system_pkg::*;
#(
  parameter int RAM_BYTES = 65536,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wd,
  input  logic [1:0]  mem_rd_unit,
  input  logic [1:0]  mem_wd_unit,
  output logic [31:0] mem_rd,
  input  logic [63:0] mtime,
  input  logic [63:0] mtimecmp,
  output logic [63:0] mtime_next,
  output logic [63:0] mtimecmp_next,
  output logic        mtime_we,
  output logic        access_fault,
  output logic        addr_misaligned,
  output logic [31:0] tohost,
  output logic        halt
);

  localparam int RAM_AW = $clog2(RAM_BYTES);
  localparam int WAW    = (RAM_AW > 2) ? RAM_AW - 2 : 1;

  logic        req, ok, st;
  mem_unit_t   unit;
  logic [1:0]  off;
  logic        in_ram, in_mcmp, in_mtime, in_toh, mapped;
  logic [3:0]  be;
  logic [31:0] wlanes, mask32, ram_rdata, rd_word, rd_shift;
  logic [63:0] mask64, data64;

  // A combined load+store is a store, so the store size governs.
  assign unit = mem_unit_t'(mem_we ? mem_wd_unit : mem_rd_unit);
  assign off  = mem_addr[1:0];
  assign req  = mem_re | mem_we;

  assign in_ram   = (mem_addr >> RAM_AW) == 32'd0;
  assign in_mcmp  = mem_addr[31:3] == MTIMECMP_ADDR[31:3];
  assign in_mtime = mem_addr[31:3] == MTIME_ADDR[31:3];
  assign in_toh   = mem_addr[31:2] == TOHOST_ADDR[31:2];
  assign mapped   = in_ram | in_mcmp | in_mtime | in_toh;

  // Misalignment wins over any access fault.
  assign addr_misaligned = req && ((unit == UNIT_HALF && off[0]) ||
                                   (unit == UNIT_WORD && off != 2'd0));
  assign access_fault    = req && !addr_misaligned &&
                           (!mapped || unit == 2'd3 || (in_toh && unit != UNIT_WORD));
  assign ok = req && !addr_misaligned && !access_fault;
  assign st = ok && mem_we;

  assign be     = lane_be(unit, off);
  assign wlanes = mem_wd << {off, 3'b000};
  always_comb begin
    mask32 = '0;
    for (int i = 0; i < 4; i++) mask32[8*i +: 8] = {8{be[i]}};
  end

  // A store never lands on the RAM while reset is held.
  ram #(.WORDS(RAM_BYTES / 4), .AW(WAW), .INIT_FILE(INIT_FILE)) u_ram (
    .clk  (clk),
    .we   (st && in_ram && reset),
    .be   (be),
    .addr (mem_addr[WAW+1:2]),
    .wdata(wlanes),
    .rdata(ram_rdata)
  );

  always_comb begin
    rd_word = '0;
    if (in_ram)        rd_word = ram_rdata;
    else if (in_mcmp)  rd_word = mem_addr[2] ? mtimecmp[63:32] : mtimecmp[31:0];
    else if (in_mtime) rd_word = mem_addr[2] ? mtime[63:32] : mtime[31:0];
    else if (in_toh)   rd_word = tohost;
    rd_shift = rd_word >> {off, 3'b000};
    mem_rd   = '0;
    if (ok) begin
      case (unit)
        UNIT_BYTE: mem_rd = {24'b0, rd_shift[7:0]};
        UNIT_HALF: mem_rd = {16'b0, rd_shift[15:0]};
        default:   mem_rd = rd_shift;
      endcase
    end
  end

  // Timer windows: lane mask lifted into the addressed 32-bit half.
  assign mask64 = mem_addr[2] ? {mask32, 32'b0} : {32'b0, mask32};
  assign data64 = {wlanes, wlanes};

  assign mtime_we      = st && in_mtime;
  assign mtime_next    = mtime_we ? ((mtime & ~mask64) | (data64 & mask64)) : mtime;
  assign mtimecmp_next = (st && in_mcmp) ? ((mtimecmp & ~mask64) | (data64 & mask64))
                                         : mtimecmp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tohost <= '0;
      halt   <= 1'b0;
    end else if (st && in_toh) begin
      tohost <= mem_wd;
      halt   <= halt | (mem_wd != 32'd0);
    end
  end

endmodule

// File: tb/tb_mem_system.sv
// Randomized bench for mem_system against a byte-level reference model.
module tb_mem_system;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_re = 1'b0, mem_we = 1'b0;
  logic [31:0] mem_addr = '0, mem_wd = '0;
  logic [1:0]  mem_rd_unit = '0, mem_wd_unit = '0;
  logic [31:0] mem_rd;
  logic [63:0] mtime = '0, mtimecmp = '0;
  logic [63:0] mtime_next, mtimecmp_next;
  logic        mtime_we, access_fault, addr_misaligned;
  logic [31:0] tohost;
  logic        halt;

  mem_system dut (
    .clk(clk), .reset(reset), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd_unit(mem_rd_unit),
    .mem_wd_unit(mem_wd_unit), .mem_rd(mem_rd), .mtime(mtime),
    .mtimecmp(mtimecmp), .mtime_next(mtime_next), .mtimecmp_next(mtimecmp_next),
    .mtime_we(mtime_we), .access_fault(access_fault),
    .addr_misaligned(addr_misaligned), .tohost(tohost), .halt(halt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] m_toh = '0;
  logic        m_halt = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request cycle: drive after the edge, check mid-cycle, update the model.
  task automatic step(input logic re, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] u,
                      input logic [63:0] mt, input logic [63:0] mc);
    int          sz;
    logic        req, mis, flt, ok, known, r_ram, r_mc, r_mt, r_th;
    logic [31:0] exp_rd;
    logic [63:0] exp_mtn, exp_mcn;
    logic [7:0]  b;
    @(posedge clk); #1;
    mem_re = re; mem_we = we; mem_addr = a; mem_wd = wd;
    mem_rd_unit = u; mem_wd_unit = u; mtime = mt; mtimecmp = mc;
    #2;
    sz    = (u == 2'd0) ? 1 : (u == 2'd1) ? 2 : (u == 2'd2) ? 4 : 0;
    req   = re | we;
    r_ram = a < 32'd65536;
    r_mc  = a >= 32'h0200_4000 && a < 32'h0200_4008;
    r_mt  = a >= 32'h0200_BFF8 && a < 32'h0200_C000;
    r_th  = a >= 32'h1000_0000 && a < 32'h1000_0004;
    mis   = req && ((sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0));
    flt   = req && !mis && (!(r_ram || r_mc || r_mt || r_th) || sz == 0 || (r_th && sz != 4));
    ok    = req && !mis && !flt;
    exp_rd = '0; known = 1'b1;
    if (ok) begin
      for (int k = 0; k < sz; k++) begin
        b = '0;
        if (r_ram) begin
          if (ref_mem.exists(a + k)) b = ref_mem[a + k]; else known = 1'b0;
        end
        else if (r_mc) b = 8'(mc >> (8 * (a - 32'h0200_4000 + k)));
        else if (r_mt) b = 8'(mt >> (8 * (a - 32'h0200_BFF8 + k)));
        else           b = 8'(m_toh >> (8 * (a - 32'h1000_0000 + k)));
        exp_rd = exp_rd | (32'(b) << (8 * k));
      end
    end
    exp_mtn = mt; exp_mcn = mc;
    if (ok && we && r_mt)
      for (int k = 0; k < sz; k++) exp_mtn[8 * (a - 32'h0200_BFF8 + k) +: 8] = wd[8*k +: 8];
    if (ok && we && r_mc)
      for (int k = 0; k < sz; k++) exp_mcn[8 * (a - 32'h0200_4000 + k) +: 8] = wd[8*k +: 8];

    chk("misaligned", addr_misaligned, mis);
    chk("access_fault", access_fault, flt);
    if ((re && known) || (req && !ok)) chk("mem_rd", mem_rd, exp_rd);
    chk("mtime_we", mtime_we, ok && we && r_mt);
    chk("mtime_next", mtime_next, exp_mtn);
    chk("mtimecmp_next", mtimecmp_next, exp_mcn);
    chk("tohost", tohost, m_toh);
    chk("halt", halt, m_halt);

    if (ok && we) begin
      if (r_ram) for (int k = 0; k < sz; k++) ref_mem[a + k] = wd[8*k +: 8];
      if (r_th) begin
        m_toh  = wd;
        m_halt = m_halt | (wd != 32'd0);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 64'h0, 64'h0);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  u;
    logic        re, we;
    logic [63:0] mt, mc;
    int          sel;

    #3;
    chk("reset_tohost", tohost, 32'h0);
    chk("reset_halt", halt, 1'b0);
    #9 reset = 1'b1;

    // word store then sub-word loads
    step(0, 1, 32'h100, 32'hDEAD_BEEF, 2'd2, 64'h0, 64'h0);
    step(1, 0, 32'h102, 32'h0, 2'd0, 64'h0, 64'h0);
    chk("byte_load_102", mem_rd, 32'h0000_00AD);
    step(1, 0, 32'h102, 32'h0, 2'd1, 64'h0, 64'h0);
    chk("half_load_102", mem_rd, 32'h0000_DEAD);

    // misaligned store leaves RAM alone; unmapped load faults
    step(0, 1, 32'h101, 32'h1234, 2'd1, 64'h0, 64'h0);
    chk("mis_half_store", addr_misaligned, 1'b1);
    chk("mis_no_fault", access_fault, 1'b0);
    step(1, 0, 32'h100, 32'h0, 2'd2, 64'h0, 64'h0);
    chk("ram_unchanged", mem_rd, 32'hDEAD_BEEF);
    step(1, 0, 32'h2000_0000, 32'h0, 2'd2, 64'h0, 64'h0);
    chk("unmapped_fault", access_fault, 1'b1);
    chk("unmapped_rd", mem_rd, 32'h0);

    // timer merges
    step(0, 1, 32'h0200_BFFD, 32'h7F, 2'd0, 64'h0000_0005_0000_0000, 64'h0);
    chk("mtime_we_byte", mtime_we, 1'b1);
    chk("mtime_merge", mtime_next, 64'h0000_7F05_0000_0000);
    step(0, 1, 32'h0200_4000, 32'h10, 2'd2, 64'h0, '1);
    chk("mtimecmp_merge", mtimecmp_next, 64'hFFFF_FFFF_0000_0010);
    chk("mtimecmp_no_we", mtime_we, 1'b0);
    step(0, 1, 32'h0200_4000, 32'h10, 2'd3, 64'h0, '1);
    chk("unit3_fault", access_fault, 1'b1);

    // tohost / halt
    step(0, 1, 32'h1000_0000, 32'h1, 2'd2, 64'h0, 64'h0);
    idle();
    chk("tohost_1", tohost, 32'h1);
    chk("halt_set", halt, 1'b1);
    step(0, 1, 32'h1000_0000, 32'h0, 2'd2, 64'h0, 64'h0);
    idle();
    chk("halt_sticky", halt, 1'b1);
    step(0, 1, 32'h1000_0000, 32'h5, 2'd1, 64'h0, 64'h0);
    chk("tohost_half_fault", access_fault, 1'b1);

    // preload a RAM window so random loads have defined data
    for (int i = 0; i < 16; i++)
      step(0, 1, 32'h200 + 32'(4 * i), $urandom, 2'd2, 64'h0, 64'h0);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 6);
      u   = 2'($urandom_range(0, 3));
      case (sel)
        0, 1, 2: a = 32'h200 + 32'($urandom_range(0, 63));
        3:       a = 32'h0200_BFF8 + 32'($urandom_range(0, 7));
        4:       a = 32'h0200_4000 + 32'($urandom_range(0, 7));
        5:       a = 32'h1000_0000 + 32'($urandom_range(0, 3));
        default: a = 32'h2000_0000 | 32'($urandom_range(0, 32'hFFFF));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (u == 2'd1) a[0] = 1'b0;
        if (u == 2'd2) a[1:0] = 2'b00;
      end
      case ($urandom_range(0, 3))
        0:       begin re = 1; we = 0; end
        1:       begin re = 0; we = 1; end
        2:       begin re = 1; we = 1; end
        default: begin re = 0; we = 0; end
      endcase
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      mt = {$urandom, $urandom};
      mc = {$urandom, $urandom};
      step(re, we, a, wd, u, mt, mc);
    end

    // asynchronous reset with halt set, no clock edge in between
    step(0, 1, 32'h1000_0000, 32'h5, 2'd2, 64'h0, 64'h0);
    idle();
    chk("pre_reset_halt", halt, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("async_tohost", tohost, 32'h0);
    chk("async_halt", halt, 1'b0);
    m_toh = '0; m_halt = 1'b0;
    #10 reset = 1'b1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_system.md
# mem_system

Memory-side stage directly downstream of the multi-cycle core: it consumes the core's load/store requests and produces read data, the fault flags, and the merged next values for the core-held `mtime`/`mtimecmp` registers. It contains the on-chip RAM, the CLINT-style timer register window, and a `tohost` halt register, and it sits between the core and the top-level test harness.

## Interface
- `RAM_BYTES`, 65536 — RAM size in bytes; a power of two, at least 4.
- `INIT_FILE`, "" — hex image loaded into RAM at elaboration; empty means no preload.
- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `mem_re`, `mem_we` in 1 — load and store request, held for the access cycle.
- `mem_addr` in 32 — byte address.
- `mem_wd` in 32 — store data, right-aligned.
- `mem_rd_unit`, `mem_wd_unit` in 2 — access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `mem_rd` out 32 — load data, right-aligned, upper bits zero. The core performs sign extension.
- `mtime`, `mtimecmp` in 64 — current timer values held in the core.
- `mtime_next`, `mtimecmp_next` out 64 — merged timer values.
- `mtime_we` out 1 — core loads `mtime_next` into `mtime` on this cycle.
- `access_fault`, `addr_misaligned` out 1 — combinational fault flags for the current request.
- `tohost` out 32 — last value written to the tohost register.
- `halt` out 1 — sticky; set when a nonzero value is written to tohost.

## Operation
- Address map:
  - RAM at `[0, RAM_BYTES)`.
  - `mtimecmp` low word at 0x0200_4000, high word at 0x0200_4004.
  - `mtime` low word at 0x0200_BFF8, high word at 0x0200_BFFC.
  - `tohost` at 0x1000_0000, word access only.
  - Any other address is unmapped.
- Fault flags are evaluated only when `mem_re | mem_we`; otherwise both are 0.
- `addr_misaligned` is set for a half access with `addr[0]=1`, or a word access with `addr[1:0]≠0`.
- `access_fault` is set for an unmapped address, unit 3, or a non-word access to tohost.
- `addr_misaligned` has priority: when it is 1, `access_fault` is 0.
- A faulting request performs no state change and no `mtime_we`; `mem_rd` is 0.
- Loads are combinational:
  - `mem_rd` = the addressed unit, extracted from the 32-bit word at `addr[31:2]`.
  - Timer windows return the matching 32-bit half of `mtime`/`mtimecmp`, with byte/half extraction as for RAM.
  - A tohost read returns `tohost`.
- Stores:
  - RAM: byte lanes are selected by unit and `addr[1:0]`.
  - mtime window: `mtime_next` = `mtime` with the addressed bytes replaced by `mem_wd` lanes, and `mtime_we=1`.
  - mtimecmp window: same merge, placed on `mtimecmp_next`.
  - Otherwise `mtime_next=mtime`, `mtimecmp_next=mtimecmp`, and `mtime_we=0`.
- `mem_re & mem_we` together is treated as a store; `mem_rd` shows the pre-store data.
- Store to tohost: `tohost ← mem_wd` at the clock edge; `halt ← halt | (mem_wd≠0)`.

## Timing
- Loads: zero latency (combinational).
- RAM and tohost writes commit at the rising `clk` edge of the request cycle. A load of the same address in the next cycle returns the new data.
- `mtime_we`, `mtime_next` and `mtimecmp_next` are combinational in the store cycle; the core registers them at that edge.
- Reset values: `tohost=0`, `halt=0`. All other outputs are combinational from their inputs. RAM contents are not reset (`INIT_FILE` or X).
- Reset asserted mid-store: the store is dropped, tohost and halt clear immediately, and RAM is undefined only for that cycle's write.
- Once `halt` is set, further stores still act normally; `halt` stays 1 until reset.

## Structure
- The shared `enums` package gains:
  - `mem_unit_t` (`UNIT_BYTE`, `UNIT_HALF`, `UNIT_WORD`).
  - Address constants `MTIMECMP_ADDR`, `MTIME_ADDR`, `TOHOST_ADDR`.
- One sub-module, `ram`: word-organised, 4-bit byte-enable synchronous write, asynchronous read, `INIT_FILE` preload.
- Decode, lane/byte-enable generation, 64-bit merge, and the tohost register live in `mem_system`.

## Test plan
- **Word store/load:** word store 0xDEADBEEF to 0x100, then byte load 0x102 → `mem_rd=0x000000AD`; half load 0x102 → 0x0000DEAD; no flags.
- **Misaligned and fault:** half store to 0x101 → `addr_misaligned=1`, `access_fault=0`, RAM unchanged. Word load 0x2000_0000 → `access_fault=1`, `mem_rd=0`.
- **mtime merge:** with `mtime=0x0000000500000000`, byte store 0x7F to 0x0200_BFFD → `mtime_we=1`, `mtime_next=0x00007F0500000000`.
- **mtimecmp and unit 3:**
  - Word store 0x10 to 0x0200_4000 with `mtimecmp=~0` → `mtimecmp_next=0xFFFFFFFF00000010`, `mtime_we=0`.
  - Unit 3 to the same address → `access_fault=1`.
- **tohost:** word store 1 → `tohost=1` and `halt=1` after the edge. A later store of 0 → `halt` stays 1. Half store to tohost → `access_fault`.
- **Async reset:** assert `reset` low mid-cycle after halt → `tohost=0` and `halt=0` immediately, without waiting for a clock edge.
